// File: rtl/game_pkg.sv
// -----------------------------------------------------------------------------
// game_pkg
// Shared game constants so the collision/score logic and the HUD/score
// renderer agree on counter widths and scoring rules.
//   AST_COUNT_DEF       default number of asteroid instances
//   SCORE_W_DEF         default score counter width
//   LIVES_W_DEF         default lives counter width
//   LIVES_INIT_DEF      lives loaded at reset
//   POINTS_PER_HIT_DEF  score added per asteroid destroyed by the bullet
// -----------------------------------------------------------------------------
package game_pkg;

    localparam int AST_COUNT_DEF      = 10;
    localparam int SCORE_W_DEF        = 16;
    localparam int LIVES_W_DEF        = 2;
    localparam int LIVES_INIT_DEF     = 3;
    localparam int POINTS_PER_HIT_DEF = 1;

    // Width needed to hold a count of 0..n.
    function automatic int count_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/collision_detector_popcount.sv
// -----------------------------------------------------------------------------
// popcount
// Purely combinational population count.
//   in_vec  in   N          bits to count
//   count   out  clog2(N+1) number of set bits in in_vec
// -----------------------------------------------------------------------------
module popcount
    import game_pkg::*;
#(
    parameter int N = AST_COUNT_DEF
) (
    input  logic [N-1:0]          in_vec,
    output logic [count_w(N)-1:0] count
);

    localparam int CW = count_w(N);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(in_vec[i]);
        end
    end

endmodule

// File: rtl/collision_detector.sv
// -----------------------------------------------------------------------------
// collision_detector
// Pixel-domain collision detection between the bullet/ship sprites and the
// asteroid instances. Overlaps are accumulated over a frame and committed on
// the frame pulse, producing one-cycle shot/bullet_hit/ship_hit pulses and
// updating score, lives and game_over.
//   clk             in   pixel clock
//   rst             in   asynchronous, active-high reset
//   frame           in   one-cycle pulse at start of vertical blanking
//   ast_drawing     in   per-asteroid "drawing this pixel" flags
//   ast_enabled     in   per-asteroid "alive" flags
//   bullet_drawing  in   bullet sprite drawing this pixel
//   ship_drawing    in   ship sprite drawing this pixel
//   shot            out  one-cycle pulse per destroyed asteroid
//   bullet_hit      out  one-cycle pulse: bullet struck an asteroid last frame
//   ship_hit        out  one-cycle pulse: ship collided last frame
//   score           out  saturating score counter
//   lives           out  remaining lives
//   game_over       out  sticky until reset once lives reach 0
// -----------------------------------------------------------------------------
module collision_detector
    import game_pkg::*;
#(
    parameter int ASTEROID_COUNT = AST_COUNT_DEF,
    parameter int SCORE_W        = SCORE_W_DEF,
    parameter int LIVES_W        = LIVES_W_DEF,
    parameter int LIVES_INIT     = LIVES_INIT_DEF,
    parameter int POINTS_PER_HIT = POINTS_PER_HIT_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame,
    input  logic [ASTEROID_COUNT-1:0] ast_drawing,
    input  logic [ASTEROID_COUNT-1:0] ast_enabled,
    input  logic                      bullet_drawing,
    input  logic                      ship_drawing,
    output logic [ASTEROID_COUNT-1:0] shot,
    output logic                      bullet_hit,
    output logic                      ship_hit,
    output logic [SCORE_W-1:0]        score,
    output logic [LIVES_W-1:0]        lives,
    output logic                      game_over
);

    localparam int NB_W  = count_w(ASTEROID_COUNT);
    // Wide enough that score + nb*POINTS_PER_HIT can never overflow before
    // the saturation compare.
    localparam int SUM_W = SCORE_W + NB_W + 33;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                    input logic [NB_W-1:0]    n);
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] lim;
        lim = {{(SUM_W - SCORE_W){1'b0}}, {SCORE_W{1'b1}}};
        sum = SUM_W'(a) + SUM_W'(n) * SUM_W'(POINTS_PER_HIT);
        if (sum > lim) begin
            return {SCORE_W{1'b1}};
        end
        return sum[SCORE_W-1:0];
    endfunction

    logic [ASTEROID_COUNT-1:0] bhit;
    logic [ASTEROID_COUNT-1:0] shit;
    logic [ASTEROID_COUNT-1:0] acc_b;
    logic [ASTEROID_COUNT-1:0] acc_s;
    logic [ASTEROID_COUNT-1:0] kill;
    logic [NB_W-1:0]           nb;
    logic                      any_b;
    logic                      any_s;

    logic [ASTEROID_COUNT-1:0] shot_p1;
    logic                      bullet_hit_p1;
    logic                      ship_hit_p1;
    logic [SCORE_W-1:0]        score_p1;
    logic [LIVES_W-1:0]        lives_p1;
    logic                      game_over_p1;

    // ---- stage 0: per-pixel overlap detection and frame accumulation ----
    assign bhit = {ASTEROID_COUNT{bullet_drawing}} & ast_drawing & ast_enabled;
    assign shit = {ASTEROID_COUNT{ship_drawing}}   & ast_drawing & ast_enabled;

    // On the frame pulse the accumulators restart from this cycle's hits, so
    // an overlap coincident with the pulse is counted in the following frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_b <= '0;
            acc_s <= '0;
        end else if (frame) begin
            acc_b <= bhit;
            acc_s <= shit;
        end else begin
            acc_b <= acc_b | bhit;
            acc_s <= acc_s | shit;
        end
    end

    assign kill  = acc_b | acc_s;
    assign any_b = |acc_b;
    assign any_s = |acc_s;

    popcount #(
        .N (ASTEROID_COUNT)
    ) u_popcount (
        .in_vec (acc_b),
        .count  (nb)
    );

    // ---- stage 1: frame commit of pulses, score, lives, game_over ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shot_p1       <= '0;
            bullet_hit_p1 <= 1'b0;
            ship_hit_p1   <= 1'b0;
            score_p1      <= '0;
            lives_p1      <= LIVES_W'(LIVES_INIT);
            game_over_p1  <= 1'b0;
        end else begin
            shot_p1       <= '0;
            bullet_hit_p1 <= 1'b0;
            ship_hit_p1   <= 1'b0;
            if (frame && !game_over_p1) begin
                shot_p1       <= kill;
                bullet_hit_p1 <= any_b;
                ship_hit_p1   <= any_s;
                // Only bullet kills score; ship-collision kills are free.
                score_p1      <= sat_add(score_p1, nb);
                // One life per frame at most, however many asteroids hit.
                if (any_s && (lives_p1 != '0)) begin
                    lives_p1 <= lives_p1 - LIVES_W'(1);
                    if (lives_p1 == LIVES_W'(1)) begin
                        game_over_p1 <= 1'b1;
                    end
                end
            end
        end
    end

    assign shot       = shot_p1;
    assign bullet_hit = bullet_hit_p1;
    assign ship_hit   = ship_hit_p1;
    assign score      = score_p1;
    assign lives      = lives_p1;
    assign game_over  = game_over_p1;

endmodule

// File: tb/tb_collision_detector.sv
module tb_collision_detector;

    localparam logic [9:0] E = 10'h3FF;
    localparam logic [9:0] Z = 10'h000;

    typedef struct {
        int         step;
        logic       frame;
        logic [9:0] ad;
        logic [9:0] ae;
        logic       b;
        logic       s;
        logic [9:0] shot;
        logic       bh;
        logic       sh;
        logic [15:0] score;
        logic [1:0] lives;
        logic       go;
        logic [1:0] score2;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame = 1'b0;
    logic [9:0]  ast_drawing = '0;
    logic [9:0]  ast_enabled = '0;
    logic        bullet_drawing = 1'b0;
    logic        ship_drawing = 1'b0;

    logic [9:0]  shot, shot2;
    logic        bullet_hit, ship_hit, game_over;
    logic        bullet_hit2, ship_hit2, game_over2;
    logic [15:0] score;
    logic [1:0]  score2;
    logic [1:0]  lives, lives2;

    int n_vec = 0;
    int n_bad = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    collision_detector dut (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .ast_drawing    (ast_drawing),
        .ast_enabled    (ast_enabled),
        .bullet_drawing (bullet_drawing),
        .ship_drawing   (ship_drawing),
        .shot           (shot),
        .bullet_hit     (bullet_hit),
        .ship_hit       (ship_hit),
        .score          (score),
        .lives          (lives),
        .game_over      (game_over)
    );

    // Narrow-score instance shares all stimulus; used to reach saturation.
    collision_detector #(
        .SCORE_W (2)
    ) dut_sat (
        .clk            (clk),
        .rst            (rst),
        .frame          (frame),
        .ast_drawing    (ast_drawing),
        .ast_enabled    (ast_enabled),
        .bullet_drawing (bullet_drawing),
        .ship_drawing   (ship_drawing),
        .shot           (shot2),
        .bullet_hit     (bullet_hit2),
        .ship_hit       (ship_hit2),
        .score          (score2),
        .lives          (lives2),
        .game_over      (game_over2)
    );

    function automatic vec_t mk(input int step, input logic f,
                                input logic [9:0] ad, input logic [9:0] ae,
                                input logic b, input logic s,
                                input logic [9:0] sht, input logic bh, input logic sh,
                                input logic [15:0] sc, input logic [1:0] lv,
                                input logic go, input logic [1:0] sc2);
        vec_t v;
        v.step = step; v.frame = f; v.ad = ad; v.ae = ae; v.b = b; v.s = s;
        v.shot = sht; v.bh = bh; v.sh = sh; v.score = sc; v.lives = lv;
        v.go = go; v.score2 = sc2;
        return v;
    endfunction

    task automatic cmp(input vec_t v);
        n_vec++;
        if (shot !== v.shot || bullet_hit !== v.bh || ship_hit !== v.sh ||
            score !== v.score || lives !== v.lives || game_over !== v.go ||
            score2 !== v.score2 || lives2 !== v.lives || game_over2 !== v.go) begin
            n_bad++;
            $display("FAIL vec%0d step%0d: got shot=%h bh=%b sh=%b score=%0d lives=%0d go=%b score2=%0d lives2=%0d go2=%b; want shot=%h bh=%b sh=%b score=%0d lives=%0d go=%b score2=%0d",
                     n_vec, v.step, shot, bullet_hit, ship_hit, score, lives, game_over,
                     score2, lives2, game_over2, v.shot, v.bh, v.sh, v.score, v.lives,
                     v.go, v.score2);
        end
    endtask

    task automatic apply(input vec_t v);
        @(negedge clk);
        frame          = v.frame;
        ast_drawing    = v.ad;
        ast_enabled    = v.ae;
        bullet_drawing = v.b;
        ship_drawing   = v.s;
        @(posedge clk);
        #1;
        cmp(v);
    endtask

    initial begin
        // Idle: three frame pulses (two back-to-back), nothing drawn.
        vecs.push_back(mk(1, 0, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 1, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(1, 0, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        // Bullet over asteroid 2 for 5 pixels.
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(2, 0, 10'h004, E, 1, 0, Z, 0, 0, 0, 3, 0, 0));
        vecs.push_back(mk(2, 1, Z, E, 0, 0, 10'h004, 1, 0, 1, 3, 0, 1));
        vecs.push_back(mk(2, 0, Z, E, 0, 0, Z, 0, 0, 1, 3, 0, 1));
        // Bullet over asteroids 0 and 7 on different pixels.
        vecs.push_back(mk(3, 0, 10'h001, E, 1, 0, Z, 0, 0, 1, 3, 0, 1));
        vecs.push_back(mk(3, 0, 10'h080, E, 1, 0, Z, 0, 0, 1, 3, 0, 1));
        vecs.push_back(mk(3, 1, Z, E, 0, 0, 10'h081, 1, 0, 3, 3, 0, 3));
        vecs.push_back(mk(3, 0, Z, E, 0, 0, Z, 0, 0, 3, 3, 0, 3));
        // Three asteroids in one pixel; narrow score saturates at 3.
        vecs.push_back(mk(4, 0, 10'h222, E, 1, 0, Z, 0, 0, 3, 3, 0, 3));
        vecs.push_back(mk(4, 1, Z, E, 0, 0, 10'h222, 1, 0, 6, 3, 0, 3));
        vecs.push_back(mk(4, 0, Z, E, 0, 0, Z, 0, 0, 6, 3, 0, 3));
        // Overlap with a disabled asteroid: no hit from bullet or ship.
        vecs.push_back(mk(5, 0, 10'h008, 10'h3F7, 1, 1, Z, 0, 0, 6, 3, 0, 3));
        vecs.push_back(mk(5, 1, Z, E, 0, 0, Z, 0, 0, 6, 3, 0, 3));
        // Overlap coincident with frame lands in the next commit.
        vecs.push_back(mk(6, 1, 10'h010, E, 1, 0, Z, 0, 0, 6, 3, 0, 3));
        vecs.push_back(mk(6, 0, Z, E, 0, 0, Z, 0, 0, 6, 3, 0, 3));
        vecs.push_back(mk(6, 1, Z, E, 0, 0, 10'h010, 1, 0, 7, 3, 0, 3));
        vecs.push_back(mk(6, 0, Z, E, 0, 0, Z, 0, 0, 7, 3, 0, 3));
        // Ship over asteroids 4 and 5: one life lost, no score.
        vecs.push_back(mk(7, 0, 10'h010, E, 0, 1, Z, 0, 0, 7, 3, 0, 3));
        vecs.push_back(mk(7, 0, 10'h020, E, 0, 1, Z, 0, 0, 7, 3, 0, 3));
        vecs.push_back(mk(7, 1, Z, E, 0, 0, 10'h030, 0, 1, 7, 2, 0, 3));
        vecs.push_back(mk(7, 0, Z, E, 0, 0, Z, 0, 0, 7, 2, 0, 3));
        // Bullet and ship on the same asteroid: scores and costs a life.
        vecs.push_back(mk(8, 0, 10'h040, E, 1, 1, Z, 0, 0, 7, 2, 0, 3));
        vecs.push_back(mk(8, 1, Z, E, 0, 0, 10'h040, 1, 1, 8, 1, 0, 3));
        vecs.push_back(mk(8, 0, Z, E, 0, 0, Z, 0, 0, 8, 1, 0, 3));
        // Last life lost: game_over rises with the commit.
        vecs.push_back(mk(9, 0, 10'h008, E, 0, 1, Z, 0, 0, 8, 1, 0, 3));
        vecs.push_back(mk(9, 1, Z, E, 0, 0, 10'h008, 0, 1, 8, 0, 1, 3));
        vecs.push_back(mk(9, 0, Z, E, 0, 0, Z, 0, 0, 8, 0, 1, 3));
        // After game over: hits give no pulses, score/lives frozen.
        vecs.push_back(mk(10, 0, 10'h001, E, 1, 0, Z, 0, 0, 8, 0, 1, 3));
        vecs.push_back(mk(10, 1, Z, E, 0, 0, Z, 0, 0, 8, 0, 1, 3));
        vecs.push_back(mk(10, 0, 10'h002, E, 0, 1, Z, 0, 0, 8, 0, 1, 3));
        vecs.push_back(mk(10, 1, Z, E, 0, 0, Z, 0, 0, 8, 0, 1, 3));
        vecs.push_back(mk(10, 0, Z, E, 0, 0, Z, 0, 0, 8, 0, 1, 3));
        // Pending hit accumulated just before a mid-frame reset.
        vecs.push_back(mk(11, 0, 10'h004, E, 1, 0, Z, 0, 0, 8, 0, 1, 3));
        vecs.push_back(mk(11, 0, 10'h004, E, 1, 0, Z, 0, 0, 8, 0, 1, 3));

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        cmp(mk(0, 0, Z, Z, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) apply(vecs[i]);

        // Mid-frame asynchronous reset: outputs clear immediately and the
        // pending bullet hit on asteroid 2 is never reported.
        @(negedge clk);
        bullet_drawing = 1'b0;
        ast_drawing    = Z;
        #1;
        rst = 1'b1;
        #1;
        cmp(mk(12, 0, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        #1;
        rst = 1'b0;
        apply(mk(12, 1, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        apply(mk(12, 0, Z, E, 0, 0, Z, 0, 0, 0, 3, 0, 0));
        // Game is playable again after reset.
        apply(mk(13, 0, 10'h200, E, 1, 0, Z, 0, 0, 0, 3, 0, 0));
        apply(mk(13, 1, Z, E, 0, 0, 10'h200, 1, 0, 1, 3, 0, 1));
        apply(mk(13, 0, Z, E, 0, 0, Z, 0, 0, 1, 3, 0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
